// File: rtl/gpio_cmd_bridge_pkg.sv
// Shared widths, opcodes, command-word field positions, FSM states and STATUS layout
// for the GPIO command bridge.
package gpio_cmd_bridge_pkg;

   localparam int NB_GPIO    = 32;
   localparam int NB_COUNTER = 64;
   localparam int NB_SW      = 4;
   localparam int NB_LED     = 4;
   localparam int RST_CYCLES = 16;
   localparam int RST_CNT_W  = $clog2(RST_CYCLES);

   localparam int OPC_MSB    = 31;
   localparam int OPC_LSB    = 24;
   localparam int STROBE_BIT = 23;

   localparam logic [7:0] OP_RESET      = 8'h01;
   localparam logic [7:0] OP_SET_SW     = 8'h02;
   localparam logic [7:0] OP_SNAPSHOT   = 8'h03;
   localparam logic [7:0] OP_READ_WORD  = 8'h04;
   localparam logic [7:0] OP_STATUS     = 8'h05;
   localparam logic [7:0] OP_CLR_STATUS = 8'h06;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_RST_HOLD,
      ST_RESP
   } state_t;

   typedef struct packed {
      logic [7:0]        last_op;
      logic [7:0]        cmd_cnt;
      logic              overrun;
      logic              bad_op;
      logic [9:0]        rsvd;
      logic [NB_LED-1:0] led;
   } status_t;

endpackage

// File: rtl/gpio_cmd_bridge_if.sv
// MicroBlaze GPIO channel pair: command word in, response word and toggle ack out.
// Signal directions are named from the bridge's point of view.
interface gpio_cmd_bridge_if #(parameter int NB_GPIO = 32);
   logic [NB_GPIO-1:0] i_gpio_data;
   logic [NB_GPIO-1:0] o_gpio_data;
   logic               o_gpio_ack;

   modport master (output i_gpio_data, input o_gpio_data, input o_gpio_ack);
   modport slave  (input i_gpio_data, output o_gpio_data, output o_gpio_ack);
endinterface

// File: rtl/gpio_cmd_bridge_counter_snapshot.sv
// Four counter capture registers loaded together on one enable; 3-bit select returns
// one 32-bit half of one captured counter, combinationally from the registers.
module gpio_cmd_bridge_counter_snapshot
   import gpio_cmd_bridge_pkg::*;
(
   input  logic                  clock,
   input  logic                  i_reset,
   input  logic                  i_capture,
   input  logic [NB_COUNTER-1:0] i_error_i,
   input  logic [NB_COUNTER-1:0] i_error_q,
   input  logic [NB_COUNTER-1:0] i_bits_i,
   input  logic [NB_COUNTER-1:0] i_bits_q,
   input  logic [2:0]            i_sel,
   output logic [NB_GPIO-1:0]    o_word
);

   logic [NB_COUNTER-1:0] r_snap [4];
   logic [NB_COUNTER-1:0] w_cnt;

   always_ff @(posedge clock) begin
      if (!i_reset) begin
         for (int k = 0; k < 4; k++) r_snap[k] <= '0;
      end else if (i_capture) begin
         r_snap[0] <= i_error_i;
         r_snap[1] <= i_error_q;
         r_snap[2] <= i_bits_i;
         r_snap[3] <= i_bits_q;
      end
   end

   assign w_cnt  = r_snap[i_sel[2:1]];
   assign o_word = i_sel[0] ? w_cnt[2*NB_GPIO-1:NB_GPIO] : w_cnt[NB_GPIO-1:0];

endmodule

// File: rtl/gpio_cmd_bridge.sv
// Decodes strobed GPIO command words into datapath reset/switch controls and returns
// snapshot/status words; response and ack toggle land 2 clocks after the strobe edge (RESET: +18).
module gpio_cmd_bridge
   import gpio_cmd_bridge_pkg::*;
(
   input  logic                  clock,
   input  logic                  i_reset,
   gpio_cmd_bridge_if.slave      gpio,
   output logic                  o_tx_reset,
   output logic [NB_SW-1:0]      o_sw,
   input  logic [NB_LED-1:0]     i_led,
   input  logic [NB_COUNTER-1:0] i_error_i,
   input  logic [NB_COUNTER-1:0] i_error_q,
   input  logic [NB_COUNTER-1:0] i_bits_i,
   input  logic [NB_COUNTER-1:0] i_bits_q
);

   state_t                r_state;
   logic [NB_GPIO-1:0]    r_cmd;
   logic                  r_strb_d;
   logic [7:0]            r_op;
   logic [NB_SW-1:0]      r_arg;
   logic [RST_CNT_W-1:0]  r_rst_cnt;
   logic [NB_GPIO-1:0]    r_rsp;
   logic [NB_GPIO-1:0]    r_gpio_data;
   logic                  r_ack;
   logic [NB_SW-1:0]      r_sw;
   logic                  r_tx_reset;
   logic [7:0]            r_last_op;
   logic [7:0]            r_cmd_cnt;
   logic                  r_overrun;
   logic                  r_bad_op;

   logic                  w_edge;
   logic                  w_capture;
   logic [NB_GPIO-1:0]    w_snap_word;
   status_t               w_status;

   assign w_edge    = r_cmd[STROBE_BIT] & ~r_strb_d;
   assign w_capture = (r_state == ST_EXEC) && (r_op == OP_SNAPSHOT);

   always_comb begin
      w_status         = '0;
      w_status.last_op = r_last_op;
      w_status.cmd_cnt = r_cmd_cnt;
      w_status.overrun = r_overrun;
      w_status.bad_op  = r_bad_op;
      w_status.led     = i_led;
   end

   gpio_cmd_bridge_counter_snapshot u_snapshot (
      .clock     (clock),
      .i_reset   (i_reset),
      .i_capture (w_capture),
      .i_error_i (i_error_i),
      .i_error_q (i_error_q),
      .i_bits_i  (i_bits_i),
      .i_bits_q  (i_bits_q),
      .i_sel     (r_arg[2:0]),
      .o_word    (w_snap_word)
   );

   always_ff @(posedge clock) begin
      if (!i_reset) begin
         r_state     <= ST_IDLE;
         r_cmd       <= '0;
         r_strb_d    <= 1'b0;
         r_op        <= '0;
         r_arg       <= '0;
         r_rst_cnt   <= '0;
         r_rsp       <= '0;
         r_gpio_data <= '0;
         r_ack       <= 1'b0;
         r_sw        <= '0;
         r_tx_reset  <= 1'b0;
         r_last_op   <= '0;
         r_cmd_cnt   <= '0;
         r_overrun   <= 1'b0;
         r_bad_op    <= 1'b0;
      end else begin
         r_cmd    <= gpio.i_gpio_data;
         r_strb_d <= r_cmd[STROBE_BIT];
         case (r_state)
            ST_IDLE: begin
               r_tx_reset <= 1'b1;
               if (w_edge) begin
                  r_op    <= r_cmd[OPC_MSB:OPC_LSB];
                  r_arg   <= r_cmd[NB_SW-1:0];
                  r_state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               r_last_op <= r_op;
               r_rsp     <= '0;
               r_state   <= ST_RESP;
               case (r_op)
                  OP_RESET: begin
                     r_tx_reset <= 1'b0;
                     r_rst_cnt  <= RST_CNT_W'(RST_CYCLES - 1);
                     r_state    <= ST_RST_HOLD;
                  end
                  OP_SET_SW: begin
                     r_sw  <= r_arg;
                     r_rsp <= NB_GPIO'(r_arg);
                  end
                  OP_SNAPSHOT:  r_rsp <= '0;
                  OP_READ_WORD: r_rsp <= w_snap_word;
                  // STATUS reports the state left by earlier commands, not this one
                  OP_STATUS:    r_rsp <= w_status;
                  OP_CLR_STATUS: begin
                     r_overrun <= 1'b0;
                     r_bad_op  <= 1'b0;
                     r_cmd_cnt <= '0;
                     r_last_op <= '0;
                  end
                  default: begin
                     r_bad_op <= 1'b1;
                     r_rsp    <= '1;
                  end
               endcase
            end
            ST_RST_HOLD: begin
               if (r_rst_cnt == '0) begin
                  r_tx_reset <= 1'b1;
                  r_state    <= ST_RESP;
               end else begin
                  r_rst_cnt <= r_rst_cnt - 1'b1;
               end
            end
            ST_RESP: begin
               r_gpio_data <= r_rsp;
               r_ack       <= ~r_ack;
               if (r_op != OP_CLR_STATUS) r_cmd_cnt <= r_cmd_cnt + 8'd1;
               r_state     <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
         // A strobe edge while busy is dropped; flag it after any clear in the same cycle
         if (w_edge && (r_state != ST_IDLE)) r_overrun <= 1'b1;
      end
   end

   assign gpio.o_gpio_data = r_gpio_data;
   assign gpio.o_gpio_ack  = r_ack;
   assign o_sw             = r_sw;
   assign o_tx_reset       = r_tx_reset;

endmodule

// File: tb/tb_gpio_cmd_bridge.sv
// Bench for gpio_cmd_bridge: schedule-based reference model compared every cycle,
// directed literal checks, then randomized command traffic with overlapping strobes.
module tb_gpio_cmd_bridge;

   localparam logic [31:0] STB = 32'h0080_0000;

   logic        clock = 1'b0;
   logic        i_reset;
   logic        o_tx_reset;
   logic [3:0]  o_sw;
   logic [3:0]  i_led;
   logic [63:0] i_error_i, i_error_q, i_bits_i, i_bits_q;

   gpio_cmd_bridge_if gpio ();

   gpio_cmd_bridge dut (
      .clock      (clock),
      .i_reset    (i_reset),
      .gpio       (gpio),
      .o_tx_reset (o_tx_reset),
      .o_sw       (o_sw),
      .i_led      (i_led),
      .i_error_i  (i_error_i),
      .i_error_q  (i_error_q),
      .i_bits_i   (i_bits_i),
      .i_bits_q   (i_bits_q)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endfunction

   // ---------------- reference model ----------------
   int          cyc = 0;
   int          done_at = -1, rsp_at = -1, sw_at = -1, snap_at = -1, lo_from = -1, lo_to = -1;
   logic [31:0] h1;
   logic        h2;
   logic [3:0]  sw_val;
   logic [31:0] rsp_val;
   logic [63:0] m_snap [4];
   logic [7:0]  m_last, m_cnt;
   logic        m_ov, m_bad;
   logic [31:0] exp_data;
   logic        exp_ack;
   logic [3:0]  exp_sw;
   logic        exp_txr;

   always @(posedge clock) begin
      cyc++;
      if (!i_reset) begin
         h1 = '0; h2 = 1'b0;
         done_at = -1; rsp_at = -1; sw_at = -1; snap_at = -1; lo_from = -1; lo_to = -1;
         for (int k = 0; k < 4; k++) m_snap[k] = '0;
         m_last = '0; m_cnt = '0; m_ov = 1'b0; m_bad = 1'b0;
         exp_data = '0; exp_ack = 1'b0; exp_sw = '0; exp_txr = 1'b0;
      end else begin
         if (cyc == snap_at) begin
            m_snap[0] = i_error_i; m_snap[1] = i_error_q;
            m_snap[2] = i_bits_i;  m_snap[3] = i_bits_q;
         end
         if (cyc == sw_at) exp_sw = sw_val;
         if (cyc == rsp_at) begin
            exp_data = rsp_val;
            exp_ack  = ~exp_ack;
         end
         exp_txr = !(cyc >= lo_from && cyc < lo_to);
         if (h1[23] && !h2) begin
            if (cyc <= done_at) m_ov = 1'b1;
            else begin
               logic [7:0]  op;
               logic [3:0]  arg;
               logic [63:0] w;
               op  = h1[31:24];
               arg = h1[3:0];
               done_at = cyc + ((op == 8'h01) ? 18 : 2);
               rsp_at  = done_at;
               rsp_val = '0;
               case (op)
                  8'h01: begin lo_from = cyc + 1; lo_to = cyc + 17; end
                  8'h02: begin sw_at = cyc + 1; sw_val = arg; rsp_val = {28'b0, arg}; end
                  8'h03: snap_at = cyc + 1;
                  8'h04: begin w = m_snap[arg[2:1]]; rsp_val = arg[0] ? w[63:32] : w[31:0]; end
                  8'h05: rsp_val = {m_last, m_cnt, m_ov, m_bad, 10'b0, i_led};
                  8'h06: ;
                  default: begin m_bad = 1'b1; rsp_val = '1; end
               endcase
               if (op == 8'h06) begin
                  m_ov = 1'b0; m_bad = 1'b0; m_cnt = '0; m_last = '0;
               end else begin
                  m_last = op;
                  m_cnt  = m_cnt + 8'd1;
               end
            end
         end
         h2 = h1[23];
         h1 = gpio.i_gpio_data;
      end
   end

   // ---------------- per-cycle compare ----------------
   logic chk_en = 1'b0;
   int   txr_low = 0;

   always @(negedge clock) begin
      if (chk_en) begin
         chk("gpio_data", gpio.o_gpio_data, exp_data);
         chk("gpio_ack",  gpio.o_gpio_ack,  exp_ack);
         chk("sw",        o_sw,             exp_sw);
         chk("tx_reset",  o_tx_reset,       exp_txr);
         if (i_reset && o_tx_reset === 1'b0) txr_low++;
      end
   end

   logic ctr_run = 1'b0;
   always @(negedge clock) begin
      if (ctr_run) begin
         i_error_i = {$urandom, $urandom}; i_error_q = {$urandom, $urandom};
         i_bits_i  = {$urandom, $urandom}; i_bits_q  = {$urandom, $urandom};
      end
   end

   // Raise strobe with cmd, drop it after 'hold' negedges; optionally pulse a second
   // command starting at 'ovr_at'. Returns negedges from strobe rise to ack change.
   task automatic issue(input logic [31:0] cmd, input int hold, input int ovr_at,
                        input logic [31:0] ovr_cmd, output int lat);
      logic a0;
      a0  = gpio.o_gpio_ack;
      lat = 0;
      @(negedge clock);
      gpio.i_gpio_data = cmd | STB;
      while (gpio.o_gpio_ack === a0 && lat < 60) begin
         @(negedge clock);
         lat++;
         if (lat == hold) gpio.i_gpio_data = cmd & ~STB;
         if (ovr_at != 0 && lat == ovr_at) gpio.i_gpio_data = ovr_cmd | STB;
         if (ovr_at != 0 && lat == ovr_at + 2) gpio.i_gpio_data = ovr_cmd & ~STB;
      end
      gpio.i_gpio_data = gpio.i_gpio_data & ~STB;
      chk("ack_within_budget", (lat < 60), 1'b1);
   endtask

   task automatic wait_idle();
      int g;
      g = 0;
      while (cyc <= done_at + 1 && g < 40) begin
         @(negedge clock);
         g++;
      end
      chk("idle_within_budget", (g < 40), 1'b1);
   endtask

   initial begin
      int lat;
      i_reset = 1'b0;
      gpio.i_gpio_data = '0;
      i_led = 4'hA;
      i_error_i = '0; i_error_q = '0; i_bits_i = '0; i_bits_q = '0;

      // reset state
      repeat (3) @(negedge clock);
      chk_en = 1'b1;
      chk("rst_data", gpio.o_gpio_data, 32'h0);
      chk("rst_ack",  gpio.o_gpio_ack,  1'b0);
      chk("rst_sw",   o_sw,             4'h0);
      chk("rst_txr",  o_tx_reset,       1'b0);
      i_reset = 1'b1;
      @(negedge clock);
      chk("release_txr", o_tx_reset, 1'b1);
      chk("release_ack", gpio.o_gpio_ack, 1'b0);
      repeat (2) @(negedge clock);

      // READ_WORD before any snapshot
      issue(32'h0400_0005, 1, 0, 32'h0, lat);
      chk("read_before_snap", gpio.o_gpio_data, 32'h0);

      // SET_SW
      issue(32'h0280_000D, 2, 0, 32'h0, lat);
      chk("setsw_sw",   o_sw, 4'hD);
      chk("setsw_data", gpio.o_gpio_data, 32'h0000_000D);
      chk("setsw_lat",  lat, 4);

      // SNAPSHOT then READ_WORD with live counter changed afterwards
      i_error_i = 64'h1234_5678_9ABC_DEF0;
      issue(32'h0300_0000, 1, 0, 32'h0, lat);
      chk("snap_data", gpio.o_gpio_data, 32'h0);
      i_error_i = 64'hFFFF_0000_FFFF_0000;
      issue(32'h0400_0000, 1, 0, 32'h0, lat);
      chk("read_lo", gpio.o_gpio_data, 32'h9ABC_DEF0);
      issue(32'h0400_0001, 1, 0, 32'h0, lat);
      chk("read_hi", gpio.o_gpio_data, 32'h1234_5678);

      // RESET with an overlapping SET_SW strobe that must be dropped
      txr_low = 0;
      issue(32'h0180_0000, 1, 5, 32'h0200_0005, lat);
      chk("reset_lat",     lat, 20);
      chk("reset_low_len", txr_low, 16);
      chk("reset_sw_kept", o_sw, 4'hD);
      chk("reset_data",    gpio.o_gpio_data, 32'h0);
      repeat (3) @(negedge clock);
      issue(32'h0500_0000, 1, 0, 32'h0, lat);
      chk("status_overrun", gpio.o_gpio_data, 32'h0106_800A);

      // bad opcode, status, clear
      issue(32'h7F80_1234, 1, 0, 32'h0, lat);
      chk("bad_data", gpio.o_gpio_data, 32'hFFFF_FFFF);
      issue(32'h0500_0000, 1, 0, 32'h0, lat);
      chk("status_bad", gpio.o_gpio_data, 32'h7F08_C00A);
      issue(32'h0600_0000, 1, 0, 32'h0, lat);
      chk("clr_data", gpio.o_gpio_data, 32'h0);
      issue(32'h0500_0000, 1, 0, 32'h0, lat);
      chk("status_cleared", gpio.o_gpio_data, 32'h0000_000A);

      // randomized traffic
      ctr_run = 1'b1;
      for (int i = 0; i < 300; i++) begin
         logic [7:0]  op;
         logic [31:0] cmd, xcmd;
         int          ovr;
         op   = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(1, 6));
         cmd  = {op, 1'b0, 23'($urandom)};
         xcmd = {8'($urandom_range(1, 6)), 1'b0, 23'($urandom)};
         ovr  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 16) : 0;
         issue(cmd, $urandom_range(1, 6), ovr, xcmd, lat);
         repeat ($urandom_range(2, 4)) @(negedge clock);
         wait_idle();
         i_led = 4'($urandom);
      end
      ctr_run = 1'b0;

      // reset in the middle of a command aborts it without an ack
      @(negedge clock);
      gpio.i_gpio_data = 32'h0280_0007;
      repeat (2) @(negedge clock);
      i_reset = 1'b0;
      @(negedge clock);
      gpio.i_gpio_data = '0;
      chk("abort_ack", gpio.o_gpio_ack, 1'b0);
      chk("abort_sw",  o_sw, 4'h0);
      i_reset = 1'b1;
      repeat (4) @(negedge clock);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
